// File: rtl/rank_filter_win.sv
// Sliding-window rank-order filter.
// Keeps the last WIN samples in a sorted slot array. Each slot is tagged with
// an age so that, in sliding mode, the oldest sample can be evicted. The output
// is the slot at a runtime-selected rank.
module rank_filter_win #(
  parameter int DATA_W = 8,
  parameter int WIN    = 9,
  parameter bit SLIDE  = 1'b1,
  parameter int RANK_W = $clog2(WIN)
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_clear,
  input  logic                     i_valid,
  input  logic [DATA_W-1:0]        i_data,
  input  logic [RANK_W-1:0]        i_rank,
  output logic                     o_valid,
  output logic [DATA_W-1:0]        o_data,
  output logic [$clog2(WIN+1)-1:0] o_count,
  output logic                     o_full
);

  localparam int                CNT_W    = $clog2(WIN+1);
  localparam logic [RANK_W-1:0] MAX_AGE  = RANK_W'(WIN-1);
  localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(WIN);

  // Registered slot array, sorted ascending with empty slots at the top.
  logic [WIN-1:0]    slot_emp;
  logic [DATA_W-1:0] slot_val [WIN];
  logic [RANK_W-1:0] slot_age [WIN];
  logic [CNT_W-1:0]  count;

  // Array after removal of the oldest entry (sliding only) and age increment.
  logic [WIN-1:0]    cmp_emp;
  logic [DATA_W-1:0] cmp_val [WIN];
  logic [RANK_W-1:0] cmp_age [WIN];

  // Neighbour views used for the one-slot shifts.
  logic [WIN-1:0]    up_emp;
  logic [DATA_W-1:0] up_val [WIN];
  logic [RANK_W-1:0] up_age [WIN];
  logic [WIN-1:0]    dn_emp;
  logic [DATA_W-1:0] dn_val [WIN];
  logic [RANK_W-1:0] dn_age [WIN];

  // Array after insertion of the new sample.
  logic [WIN-1:0]    ins_emp;
  logic [DATA_W-1:0] ins_val [WIN];
  logic [RANK_W-1:0] ins_age [WIN];

  // Post-update view used to pick the output value.
  logic [WIN-1:0]    upd_emp;
  logic [DATA_W-1:0] upd_val [WIN];

  logic              full;
  logic              accept;
  logic              do_rm;
  logic              do_ins;
  int                rm_idx;
  int                ins_idx;
  logic [RANK_W-1:0] sel;
  logic [DATA_W-1:0] out_val;

  assign full    = (count == FULL_CNT);
  assign accept  = i_valid && !i_clear;
  assign do_rm   = accept && full && SLIDE;
  assign do_ins  = accept && (!full || SLIDE);
  assign o_count = count;
  assign o_full  = full;

  // Locate the oldest occupied slot; ages are unique so the first hit is it.
  always_comb begin
    rm_idx = WIN;
    for (int i = WIN-1; i >= 0; i--) begin
      if (!slot_emp[i] && (slot_age[i] == MAX_AGE)) rm_idx = i;
    end
  end

  // Insertion point: first empty slot or first value strictly above the
  // sample, so equal values land after existing equals.
  always_comb begin
    ins_idx = WIN-1;
    for (int i = WIN-1; i >= 0; i--) begin
      if (cmp_emp[i] || (cmp_val[i] > i_data)) ins_idx = i;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < WIN; gi++) begin : g_slot
      logic              c_emp;
      logic [DATA_W-1:0] c_val;
      logic [RANK_W-1:0] c_age;
      logic              n_emp;
      logic [DATA_W-1:0] n_val;
      logic [RANK_W-1:0] n_age;

      if (gi < WIN-1) begin : g_up
        assign up_emp[gi] = slot_emp[gi+1];
        assign up_val[gi] = slot_val[gi+1];
        assign up_age[gi] = slot_age[gi+1];
      end else begin : g_top
        assign up_emp[gi] = 1'b1;
        assign up_val[gi] = '1;
        assign up_age[gi] = '0;
      end

      if (gi > 0) begin : g_dn
        assign dn_emp[gi] = cmp_emp[gi-1];
        assign dn_val[gi] = cmp_val[gi-1];
        assign dn_age[gi] = cmp_age[gi-1];
      end else begin : g_bot
        assign dn_emp[gi] = cmp_emp[0];
        assign dn_val[gi] = cmp_val[0];
        assign dn_age[gi] = cmp_age[0];
      end

      // Close the gap left by the evicted entry, then age the survivors.
      always_comb begin
        c_emp = slot_emp[gi];
        c_val = slot_val[gi];
        c_age = slot_age[gi];
        if (do_rm && (gi >= rm_idx)) begin
          c_emp = up_emp[gi];
          c_val = up_val[gi];
          c_age = up_age[gi];
        end
        if (!c_emp) c_age = c_age + 1'b1;
      end

      // Open a hole at the insertion point and drop the new sample in.
      always_comb begin
        n_emp = cmp_emp[gi];
        n_val = cmp_val[gi];
        n_age = cmp_age[gi];
        if (gi == ins_idx) begin
          n_emp = 1'b0;
          n_val = i_data;
          n_age = '0;
        end else if (gi > ins_idx) begin
          n_emp = dn_emp[gi];
          n_val = dn_val[gi];
          n_age = dn_age[gi];
        end
      end

      assign cmp_emp[gi] = c_emp;
      assign cmp_val[gi] = c_val;
      assign cmp_age[gi] = c_age;
      assign ins_emp[gi] = n_emp;
      assign ins_val[gi] = n_val;
      assign ins_age[gi] = n_age;
      assign upd_emp[gi] = do_ins ? n_emp : slot_emp[gi];
      assign upd_val[gi] = do_ins ? n_val : slot_val[gi];
    end
  endgenerate

  // Clamp the rank to the window and read the post-update slot.
  always_comb begin
    sel     = (i_rank > MAX_AGE) ? MAX_AGE : i_rank;
    out_val = upd_emp[sel] ? {DATA_W{1'b1}} : upd_val[sel];
  end

  // Slot array, occupancy and registered output.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      slot_emp <= '1;
      for (int i = 0; i < WIN; i++) begin
        slot_val[i] <= '1;
        slot_age[i] <= '0;
      end
      count   <= '0;
      o_valid <= 1'b0;
      o_data  <= '0;
    end else if (i_clear) begin
      slot_emp <= '1;
      for (int i = 0; i < WIN; i++) begin
        slot_val[i] <= '1;
        slot_age[i] <= '0;
      end
      count   <= '0;
      o_valid <= 1'b0;
    end else begin
      if (do_ins) begin
        slot_emp <= ins_emp;
        for (int i = 0; i < WIN; i++) begin
          slot_val[i] <= ins_val[i];
          slot_age[i] <= ins_age[i];
        end
        if (!full) count <= count + 1'b1;
      end
      o_valid <= accept;
      if (accept) o_data <= out_val;
    end
  end

`ifndef SYNTHESIS
  int age_hits;

  // Number of occupied slots currently carrying the oldest possible age.
  always_comb begin
    age_hits = 0;
    for (int i = 0; i < WIN; i++) begin
      if (!slot_emp[i] && (slot_age[i] == MAX_AGE)) age_hits = age_hits + 1;
    end
  end

  a_one_oldest: assert property (@(posedge i_clk) disable iff (i_rst)
    full |-> (age_hits == 1));
`endif

endmodule

// File: tb/tb_rank_filter_win.sv
// Scoreboard bench for rank_filter_win: one sliding instance and one
// accumulate-until-clear instance, both WIN=9, DATA_W=8.
module tb_rank_filter_win;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Sliding instance
  logic       s_rst, s_clear, s_valid;
  logic [7:0] s_data;
  logic [3:0] s_rank;
  logic       s_o_valid;
  logic [7:0] s_o_data;
  logic [3:0] s_o_count;
  logic       s_o_full;

  // Accumulate instance
  logic       a_rst, a_clear, a_valid;
  logic [7:0] a_data;
  logic [3:0] a_rank;
  logic       a_o_valid;
  logic [7:0] a_o_data;
  logic [3:0] a_o_count;
  logic       a_o_full;

  rank_filter_win #(.DATA_W(8), .WIN(9), .SLIDE(1'b1)) u_slide (
    .i_clk(clk), .i_rst(s_rst), .i_clear(s_clear), .i_valid(s_valid),
    .i_data(s_data), .i_rank(s_rank), .o_valid(s_o_valid), .o_data(s_o_data),
    .o_count(s_o_count), .o_full(s_o_full)
  );

  rank_filter_win #(.DATA_W(8), .WIN(9), .SLIDE(1'b0)) u_acc (
    .i_clk(clk), .i_rst(a_rst), .i_clear(a_clear), .i_valid(a_valid),
    .i_data(a_data), .i_rank(a_rank), .o_valid(a_o_valid), .o_data(a_o_data),
    .o_count(a_o_count), .o_full(a_o_full)
  );

  typedef struct {
    logic [7:0] d;
    logic [3:0] c;
  } exp_t;

  exp_t q_s[$];
  exp_t q_a[$];
  exp_t es, ea;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Slide monitor
  always @(negedge clk) begin
    if (s_o_valid === 1'b1) begin
      if (q_s.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL slide_unexpected_valid: got o_valid=1 data=%0d, expected no output", s_o_data);
      end else begin
        es = q_s.pop_front();
        $display("slide out: data=%0d count=%0d full=%0d (want %0d/%0d)", s_o_data, s_o_count, s_o_full, es.d, es.c);
        chk("slide_data", 32'(s_o_data), 32'(es.d));
        chk("slide_count", 32'(s_o_count), 32'(es.c));
        chk("slide_full", 32'(s_o_full), 32'(es.c == 4'd9));
      end
    end
  end

  // Accumulate monitor
  always @(negedge clk) begin
    if (a_o_valid === 1'b1) begin
      if (q_a.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL acc_unexpected_valid: got o_valid=1 data=%0d, expected no output", a_o_data);
      end else begin
        ea = q_a.pop_front();
        $display("acc out: data=%0d count=%0d full=%0d (want %0d/%0d)", a_o_data, a_o_count, a_o_full, ea.d, ea.c);
        chk("acc_data", 32'(a_o_data), 32'(ea.d));
        chk("acc_count", 32'(a_o_count), 32'(ea.c));
        chk("acc_full", 32'(a_o_full), 32'(ea.c == 4'd9));
      end
    end
  end

  // Issue one sample and push its expected response.
  task automatic send(input bit acc, input logic [7:0] d, input logic [3:0] r,
                      input logic [7:0] ed, input logic [3:0] ec);
    exp_t e;
    e.d = ed;
    e.c = ec;
    if (acc) begin
      q_a.push_back(e);
      a_valid = 1'b1; a_data = d; a_rank = r;
    end else begin
      q_s.push_back(e);
      s_valid = 1'b1; s_data = d; s_rank = r;
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0; a_valid = 1'b0;
    s_rank = ~r; a_rank = ~r;
  endtask

  task automatic drain();
    repeat (2) @(posedge clk);
    #1;
    chk("slide_queue_empty", 32'(q_s.size()), 32'd0);
    chk("acc_queue_empty", 32'(q_a.size()), 32'd0);
  endtask

  task automatic s_clear_pulse();
    s_clear = 1'b1;
    @(posedge clk);
    #1;
    s_clear = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    s_rst = 1'b1; s_clear = 1'b0; s_valid = 1'b0; s_data = '0; s_rank = '0;
    a_rst = 1'b1; a_clear = 1'b0; a_valid = 1'b0; a_data = '0; a_rank = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_data", 32'(s_o_data), 32'd0);
    chk("reset_valid", 32'(s_o_valid), 32'd0);
    chk("reset_count", 32'(s_o_count), 32'd0);
    chk("reset_full", 32'(s_o_full), 32'd0);
    chk("reset_acc_count", 32'(a_o_count), 32'd0);
    s_rst = 1'b0;
    a_rst = 1'b0;

    // Fill, evict, rank sweep with clamping
    send(0, 8'd5,   4'd4,  8'd255, 4'd1);
    send(0, 8'd3,   4'd4,  8'd255, 4'd2);
    send(0, 8'd8,   4'd4,  8'd255, 4'd3);
    send(0, 8'd1,   4'd4,  8'd255, 4'd4);
    send(0, 8'd9,   4'd4,  8'd9,   4'd5);
    send(0, 8'd2,   4'd4,  8'd8,   4'd6);
    send(0, 8'd7,   4'd4,  8'd7,   4'd7);
    send(0, 8'd4,   4'd4,  8'd5,   4'd8);
    send(0, 8'd6,   4'd4,  8'd5,   4'd9);
    send(0, 8'd0,   4'd4,  8'd4,   4'd9);
    send(0, 8'd10,  4'd4,  8'd6,   4'd9);
    send(0, 8'd255, 4'd8,  8'd255, 4'd9);
    send(0, 8'd3,   4'd0,  8'd0,   4'd9);
    send(0, 8'd1,   4'd7,  8'd10,  4'd9);
    send(0, 8'd20,  4'd15, 8'd255, 4'd9);
    drain();

    // Asynchronous reset between clock edges
    #2;
    s_rst = 1'b1;
    #1;
    chk("async_rst_data", 32'(s_o_data), 32'd0);
    chk("async_rst_count", 32'(s_o_count), 32'd0);
    chk("async_rst_full", 32'(s_o_full), 32'd0);
    chk("async_rst_valid", 32'(s_o_valid), 32'd0);
    s_rst = 1'b0;

    // Partial fill, then clear and repeat with rank 0
    send(0, 8'd20, 4'd4, 8'd255, 4'd1);
    send(0, 8'd10, 4'd4, 8'd255, 4'd2);
    drain();
    s_clear_pulse();
    chk("clear_count", 32'(s_o_count), 32'd0);
    chk("clear_holds_data", 32'(s_o_data), 32'd255);
    send(0, 8'd20, 4'd0, 8'd20, 4'd1);
    send(0, 8'd10, 4'd0, 8'd10, 4'd2);
    drain();

    // Ties: ten 7s, then all-ones
    s_clear_pulse();
    for (int k = 1; k <= 10; k++) begin
      send(0, 8'd7, 4'd4, (k < 5) ? 8'd255 : 8'd7, (k < 9) ? 4'(k) : 4'd9);
    end
    send(0, 8'd255, 4'd4, 8'd7, 4'd9);
    drain();

    // Clear colliding with a valid sample
    s_clear = 1'b1; s_valid = 1'b1; s_data = 8'd99; s_rank = 4'd0;
    @(posedge clk);
    #1;
    s_clear = 1'b0; s_valid = 1'b0;
    @(negedge clk);
    chk("collide_valid", 32'(s_o_valid), 32'd0);
    chk("collide_count", 32'(s_o_count), 32'd0);
    chk("collide_full", 32'(s_o_full), 32'd0);
    chk("collide_holds_data", 32'(s_o_data), 32'd7);
    @(posedge clk);
    #1;
    send(0, 8'd42, 4'd0, 8'd42, 4'd1);
    drain();

    // Accumulate-until-clear: samples after the ninth are dropped
    send(1, 8'd9, 4'd4, 8'd255, 4'd1);
    send(1, 8'd8, 4'd4, 8'd255, 4'd2);
    send(1, 8'd7, 4'd4, 8'd255, 4'd3);
    send(1, 8'd6, 4'd4, 8'd255, 4'd4);
    send(1, 8'd5, 4'd4, 8'd9,   4'd5);
    send(1, 8'd4, 4'd4, 8'd8,   4'd6);
    send(1, 8'd3, 4'd4, 8'd7,   4'd7);
    send(1, 8'd2, 4'd4, 8'd6,   4'd8);
    send(1, 8'd1, 4'd4, 8'd5,   4'd9);
    send(1, 8'd0, 4'd4, 8'd5,   4'd9);
    send(1, 8'd0, 4'd4, 8'd5,   4'd9);
    send(1, 8'd0, 4'd8, 8'd9,   4'd9);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rank_filter_win.md
Name: rank_filter_win

Overview:
- Parametrised sliding-window rank-order filter. Successor to the fixed 9-tap accumulate-until-clear median sorter.
- Keeps the last WIN samples in a sorted register array, each entry tagged with an age.
- In SLIDE mode, each new sample evicts the oldest entry. The output is the entry at a runtime-selectable rank (min, median, max or any rank in between).
- Sits in the image-filter datapath between the window address generator and the output writer.

Parameters:
DATA_W, 8, sample width in bits (unsigned).
WIN, 9, window depth; any value from 3 to 25 (odd or even).
SLIDE, 1, 1 = sliding window with oldest-first eviction; 0 = accumulate-until-clear, with samples dropped once full.
RANK_W, $clog2(WIN), width of the rank select.

Ports:
i_clk  in  1  clock; all logic is on the rising edge.
i_rst  in  1  asynchronous, active-high reset.
i_clear  in  1  synchronous one-cycle flush of the window.
i_valid  in  1  sample strobe; the sample is accepted on any cycle where i_valid=1 and i_clear=0.
i_data  in  DATA_W  sample value.
i_rank  in  RANK_W  rank select; 0 = smallest. Sampled in the same cycle as i_valid.
o_valid  out  1  one-cycle pulse, the cycle after an accepted sample.
o_data  out  DATA_W  registered rank-selected value.
o_count  out  $clog2(WIN+1)  number of occupied entries (0..WIN).
o_full  out  1  asserted when o_count==WIN.

Behaviour:
- Storage: WIN slots. Each slot holds {empty, value[DATA_W], age[RANK_W]}.
  - The array is kept sorted ascending by value, with empty slots always at the high end.
  - An empty slot compares greater than any value, including all-ones.
- Reset (i_rst=1, async): all slots empty, value all-ones, age 0. o_data=0, o_valid=0, o_count=0, o_full=0.
- i_clear (sync): same state as reset, except o_data holds its last value. Clear has priority over i_valid in the same cycle; that sample is dropped and o_valid=0 next cycle.
- Accepted sample when not full:
  - Insert at the first position whose value is strictly greater than i_data, or at the first empty slot.
  - Equal values go after existing equals (stable insertion).
  - All occupied ages increment by 1; the new entry gets age 0; o_count increments.
- Accepted sample when full, SLIDE=1:
  - Remove the unique entry with age==WIN-1, compact the array, then insert the new sample as above. All of this happens in a single cycle.
  - Surviving ages increment; o_count stays WIN.
- Accepted sample when full, SLIDE=0: the array is unchanged, but o_valid still pulses with the current rank value.
- Output:
  - One cycle after acceptance, o_valid=1 and o_data = post-update slot[min(i_rank, WIN-1)].
  - If the selected slot is empty, o_data is all-ones.
  - o_valid=0 on all other cycles. Latency is exactly 1 cycle.
  - Back-to-back i_valid is supported, giving full throughput with no bubbles.
- Ages are unique and always in the range 0..o_count-1. Assertion: exactly one age==WIN-1 whenever o_full=1.
- Reset asserted mid-stream: state clears immediately. The first accepted sample after deassertion produces o_count=1.
- i_rank may change every cycle; only the value captured with the accepted sample matters.

Test Plan:
- Fill with eviction (WIN=9, SLIDE=1, rank 4): feed 5,3,8,1,9,2,7,4,6 → 9th o_data=5, o_full=1. Feed 0 → o_data=4. Feed 10 → o_data=6. o_count stays 9.
- Partial fill: after reset, feed 20,10 with rank 4 → o_data=255 both times, o_count=2. With rank 0 → o_data=10 after the second sample.
- Rank sweep: window holds 0,1,2,4,6,7,8,9,10. Feed 255 (evicts 8) with rank 8 → 255; next sample 3 with rank 0 → 0. Rank 15 is clamped to 8.
- Ties and all-ones: feed ten 7s, then 255 → median 7 throughout, o_count=9. Eviction never removes the newest 7 (check ages via assertion).
- Clear/valid collision: full window, assert i_clear with i_valid=1 → next cycle o_valid=0, o_count=0. Next sample 42 with rank 0 → o_data=42, o_count=1.
- SLIDE=0 and async reset: feed 12 samples → o_count saturates at 9 and the median reflects the first 9 only. Pulse i_rst between clock edges → outputs are 0 immediately, before the next edge.
